// File: rtl/pipe_stage_chain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg                                                                   |
// | Shared defaults and stage naming for the in-order pipeline register chain. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int DEFAULT_N_STAGES  = 5;
  localparam int DEFAULT_PAYLOAD_W = 160;
  localparam int DEFAULT_CNT_W     = 32;

  typedef logic [$clog2(DEFAULT_N_STAGES)-1:0] stage_idx_t;

  // Stage positions for the rv32 core: fetch is youngest, writeback oldest.
  localparam stage_idx_t STAGE_F = 3'd0;
  localparam stage_idx_t STAGE_D = 3'd1;
  localparam stage_idx_t STAGE_E = 3'd2;
  localparam stage_idx_t STAGE_M = 3'd3;
  localparam stage_idx_t STAGE_W = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_chain_if                                                        |
// | Handshake, control and status bundle of the pipeline register chain.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pipe_stage_chain_if
  import pipe_pkg::*;
#(
  parameter int N_STAGES  = DEFAULT_N_STAGES,
  parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) ();

  localparam int OCC_W = $clog2(N_STAGES + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [PAYLOAD_W-1:0]          in_data;
  logic [N_STAGES-1:0]           stall_req;
  logic [N_STAGES-1:0]           flush_req;
  logic [N_STAGES-1:0]           stage_valid;
  logic [N_STAGES*PAYLOAD_W-1:0] stage_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [PAYLOAD_W-1:0]          out_data;
  logic [OCC_W-1:0]              occupancy;
  logic [CNT_W-1:0]              retired_cnt;

  modport master (
    output in_valid, in_data, stall_req, flush_req, out_ready,
    input  in_ready, stage_valid, stage_data, out_valid, out_data,
           occupancy, retired_cnt
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush_req, out_ready,
    output in_ready, stage_valid, stage_data, out_valid, out_data,
           occupancy, retired_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_chain_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_reg                                                             |
// | One pipeline stage: valid bit plus payload with kill/hold/load selection.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 160
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_hold,
  input  logic                 i_kill,
  input  logic                 i_src_valid,
  input  logic [PAYLOAD_W-1:0] i_src_data,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;

  // Kill outranks hold; payload is left untouched on hold or bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_kill) begin
      valid_d = 1'b0;
    end else if (!i_hold) begin
      valid_d = i_src_valid;
    end
    if (!i_hold && i_src_valid) begin
      data_d = i_src_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_stage_chain                                                           |
// | In-order register chain with stall back-propagation and age-ordered flush. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int N_STAGES  = DEFAULT_N_STAGES,
  parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_chain_if.slave bus
);

  localparam int OCC_W = $clog2(N_STAGES + 1);

  logic [N_STAGES-1:0]           w_hold;
  logic [N_STAGES-1:0]           w_kill;
  logic [N_STAGES-1:0]           w_src_valid;
  logic [N_STAGES-1:0]           w_valid;
  logic [PAYLOAD_W-1:0]          w_src_data [N_STAGES];
  logic [PAYLOAD_W-1:0]          w_data     [N_STAGES];
  logic [N_STAGES*PAYLOAD_W-1:0] w_stage_data;
  logic [OCC_W-1:0]              w_occupancy;
  logic                          w_out_valid;
  logic                          w_retire;
  logic [CNT_W-1:0]              retired_cnt_q, retired_cnt_d;

  // Both chains ripple from the oldest stage toward the youngest.
  always_comb begin
    w_hold = '0;
    w_kill = '0;
    w_hold[N_STAGES-1] = bus.stall_req[N_STAGES-1]
                       | (w_valid[N_STAGES-1] & ~bus.out_ready);
    w_kill[N_STAGES-1] = bus.flush_req[N_STAGES-1];
    for (int i = N_STAGES - 2; i >= 0; i--) begin
      w_hold[i] = bus.stall_req[i] | w_hold[i+1];
      w_kill[i] = bus.flush_req[i] | w_kill[i+1];
    end
  end

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_src_valid[i] = bus.in_valid & ~w_hold[0];
      assign w_src_data[i]  = bus.in_data;
    end else begin : g_body
      // A holding younger stage hands a bubble to the stage in front of it.
      assign w_src_valid[i] = w_valid[i-1] & ~w_hold[i-1];
      assign w_src_data[i]  = w_data[i-1];
    end

    pipe_stage_reg #(
      .PAYLOAD_W (PAYLOAD_W)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .i_hold      (w_hold[i]),
      .i_kill      (w_kill[i]),
      .i_src_valid (w_src_valid[i]),
      .i_src_data  (w_src_data[i]),
      .o_valid     (w_valid[i]),
      .o_data      (w_data[i])
    );
  end

  always_comb begin
    w_stage_data = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      w_stage_data[i*PAYLOAD_W +: PAYLOAD_W] = w_data[i];
    end
  end

  always_comb begin
    w_occupancy = OCC_W'($countones(w_valid));
  end

  assign w_out_valid = w_valid[N_STAGES-1]
                     & ~bus.stall_req[N_STAGES-1]
                     & ~bus.flush_req[N_STAGES-1];
  assign w_retire    = w_out_valid & bus.out_ready;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (w_retire) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign bus.in_ready    = ~w_hold[0];
  assign bus.stage_valid = w_valid;
  assign bus.stage_data  = w_stage_data;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_data[N_STAGES-1];
  assign bus.occupancy   = w_occupancy;
  assign bus.retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised in-order pipeline register chain with per-stage valid bits, stall back-propagation, bubble insertion and age-ordered flush. It replaces the per-field `stalls`/`flushes` arrays of the rv32 core with one generic block. Stage 0 is youngest (fetch side); stage N_STAGES-1 feeds writeback through a ready/valid port. Payload is an opaque packed vector, so decode/execute fields are carried as one struct cast.

## Interface
- N_STAGES, 5, number of register stages (≥2)
- PAYLOAD_W, 160, bits of payload per stage
- CNT_W, 32, width of retire counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage 0 can accept
- in_data  in  PAYLOAD_W  upstream payload
- stall_req  in  N_STAGES  bit i: stage i must hold its contents this cycle
- flush_req  in  N_STAGES  bit k: kill stages 0..k
- stage_valid  out  N_STAGES  registered valid bit per stage
- stage_data  out  N_STAGES*PAYLOAD_W  registered payload, stage i at [i*PAYLOAD_W +: PAYLOAD_W]
- out_valid  out  1  last stage presents a retirable entry
- out_ready  in  1  writeback accepts
- out_data  out  PAYLOAD_W  = stage N_STAGES-1 payload
- occupancy  out  $clog2(N_STAGES+1)  count of set stage_valid bits
- retired_cnt  out  CNT_W  entries retired since reset

## Operation
- Reset: all valid bits 0, all payload 0, retired_cnt 0; hence out_valid 0, occupancy 0, in_ready 1 (if stall_req 0).
- hold[N-1] = stall_req[N-1] | (valid[N-1] & ~out_ready); hold[i] = stall_req[i] | hold[i+1]. Stall propagates to all younger stages in the same cycle.
- kill[i] = OR of flush_req[j] for j ≥ i. A flush on stage k clears stages 0..k; stages older than k unaffected.
- Per stage i, next valid: kill[i] → 0; else hold[i] → keep; else i=0 → in_valid & in_ready; else valid[i-1] & ~hold[i-1] (bubble when younger stage holds).
- Payload loads only when stage advances and source valid; held or bubbled stages keep old payload (don't-care when valid 0).
- Kill beats hold: a held stage that is killed becomes invalid.
- in_ready = ~hold[0]. Entry accepted while kill[0] is dropped (wrong-path fetch); in_ready not deasserted by flush.
- out_valid = valid[N-1] & ~stall_req[N-1] & ~flush_req[N-1]. Retire = out_valid & out_ready; retire frees stage N-1 same edge, so full-rate streaming with no gap.
- retired_cnt += 1 per retire, wraps modulo 2^CNT_W.
- occupancy combinational popcount of registered valid bits.

## Timing
- Latency: accepted entry visible at stage i on edge i+1; out_valid N_STAGES cycles after acceptance with no stalls.
- Throughput 1 entry/cycle with out_ready held high.
- stall_req/flush_req sampled same cycle, effect at next edge; in_ready and out_valid are combinational from those inputs (no registered ready).
- Reset asserted mid-stream: all entries discarded immediately (async), counter cleared; first accept possible on first edge after deassertion.
- Full pipe with out_ready low: all stages hold, in_ready 0, no entry lost or duplicated.

## Structure
- Shared package pipe_pkg: default N_STAGES, stage index typedef, stage-name localparams (F,D,E,M,W) for the rv32 instantiation.
- One sub-module pipe_stage_reg: single stage (valid+payload flop, hold/kill/load muxing), generated N_STAGES times; hold/kill chains and counters live in the top.

## Test plan
- Stream 8 entries (payload 1..8), out_ready=1, no stalls → out_data 1..8 on consecutive cycles starting cycle 5, retired_cnt=8, occupancy returns 0.
- Pipe full, stall_req[2]=1 for 3 cycles → stages 0..2 frozen, in_ready 0, stage 3 receives bubbles, stages 3..4 drain; release → order preserved, no duplicates.
- flush_req[2] with stages 0..4 valid and in_valid=1 → next cycle stages 0..2 invalid, stages 3..4 advance, incoming entry dropped, occupancy 2 then 1.
- stall_req[1] and flush_req[1] same cycle → stages 0..1 invalid next cycle (kill wins), stage 2 gets bubble.
- out_ready=0 for 10 cycles on full pipe → out_data constant, occupancy=5, retired_cnt unchanged; out_ready=1 → 5 retires in 5 cycles.
- rst pulse mid-stream with occupancy 4 → stage_valid 0 and retired_cnt 0 immediately; CNT_W=4 with 17 retires → retired_cnt=1.
